step_pulse_gen: RTL and testbench
=================================

# step_pulse_gen

Step-pulse generator for the stepper-motor driver. It consumes the period word, direction and enable produced by the tracking controller, and emits `drv_step` pulses with a fixed high time and a programmable period. It guarantees direction setup time before the first step after a reversal, and keeps a signed step position count. It sits between the tracking controller and the external stepper driver pins, in the 50 MHz `clk` domain.

## Interface
Parameters:
- `WIDTH_N`, 17: width of the period word (holds 80000).
- `PULSE_W`, 50: `drv_step` high time in `clk` cycles (1 µs).
- `DIR_SETUP`, 25: cycles `drv_dir` must be stable before a step rising edge.
- `MIN_PERIOD`, 800: smallest legal nonzero period, in cycles. Must be > `PULSE_W`.
- `WIDTH_POS`, 32: position counter width.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `period_in`  in  `WIDTH_N`  requested step period in `clk` cycles; 0 means stop.
- `period_valid`  in  1  one-cycle strobe, synchronous to `clk`, that loads `period_in` into the shadow register.
- `drv_enable_SM`  in  1  motion request from the tracking controller.
- `drv_dir_in`  in  1  requested direction: 1 counts up, 0 counts down.
- `drv_step`  out  1  step pulse to the driver.
- `drv_dir`  out  1  direction to the driver.
- `busy`  out  1  high in every state except IDLE.
- `step_done`  out  1  one-cycle strobe on each `drv_step` rising edge.
- `period_clamped`  out  1  one-cycle strobe when a loaded period was raised to `MIN_PERIOD`.
- `position`  out  `WIDTH_POS`  signed step count.

## Operation
- All outputs are registered.
- Reset values: `drv_step`=0, `drv_dir`=0, `busy`=0, `step_done`=0, `period_clamped`=0, `position`=0. The shadow period and the active period both reset to 0. The state resets to IDLE.
- Shadow register load on `period_valid`:
  - 0 loads as 0.
  - Values 1 to `MIN_PERIOD-1` load as `MIN_PERIOD` and pulse `period_clamped`.
  - Other values load unchanged.
- States:
  - **IDLE.** Starts a step only when `drv_enable_SM`=1 and shadow≠0. If `drv_dir_in`≠`drv_dir`, go to DIR_SETUP; otherwise go to STEP_HIGH.
  - **DIR_SETUP.** `drv_dir` takes `drv_dir_in` on entry. Wait `DIR_SETUP` cycles, then go to STEP_HIGH.
  - **STEP_HIGH.** On entry:
    - copy shadow → active period;
    - set `drv_step`=1;
    - pulse `step_done`;
    - `position` ±1 per `drv_dir`, wrapping modulo 2^`WIDTH_POS`.
    - Hold for `PULSE_W` cycles, then go to STEP_LOW.
  - **STEP_LOW.** `drv_step`=0 for (active − `PULSE_W`) cycles. At the end:
    - if `drv_enable_SM`=0 or shadow=0, go to IDLE;
    - else if direction changed, go to DIR_SETUP;
    - else go to STEP_HIGH.
- Period changes take effect only at a period boundary (STEP_HIGH entry). A step is never truncated or stretched.
- If `drv_enable_SM` drops mid-step, the current period completes in full; there are no runt pulses.
- A `drv_dir_in` change during STEP_HIGH or STEP_LOW is ignored until the boundary.
- `period_valid` arriving in the same cycle as a boundary is not used for that boundary. The boundary uses the old shadow value.

## Timing
- Latency from IDLE:
  - `drv_enable_SM` sampled high at edge k, same direction → `drv_step`=1 after edge k+1.
  - Direction change → `drv_dir` changes after edge k+1, and `drv_step` rises exactly `DIR_SETUP` cycles later.
- Step period: rising edge to rising edge is exactly the active period in cycles, while the enable and direction are unchanged.
- Reversal inserts `DIR_SETUP` extra cycles between the end of STEP_LOW and the next rise.
- Worst-case stop latency is one full period: 80000 cycles (1.6 ms).
- `rst_n` low mid-pulse forces `drv_step` low immediately (asynchronously) and returns the block to IDLE.

## Structure
- Package `step_pkg` holds:
  - the state enum (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW);
  - the default `PULSE_W`, `DIR_SETUP` and `MIN_PERIOD` constants.
- One sub-module, `step_timer`: a loadable down-counter of width `WIDTH_N` with a `zero` flag. It is shared by DIR_SETUP, STEP_HIGH and STEP_LOW.

## Test plan
1. Reset, load period 800, enable, direction 0 → `drv_step` period 800 cycles, high 50 cycles. `position` decrements by 1 per step; `step_done` pulses on each rise.
2. Load 39600 mid-period at 800 → the current period ends at 800, and the next rise-to-rise interval is 39600.
3. Flip `drv_dir_in` during STEP_LOW → `drv_dir` changes at the boundary. The next rise follows 25 cycles later, then `position` counts the opposite way.
4. Load period 100 → `period_clamped` pulses once, and the running period is 800. Load 0 → the block returns to IDLE after the current period completes; `busy`=0.
5. Drop `drv_enable_SM` 10 cycles into STEP_HIGH → the pulse stays high a full 50 cycles, and the low phase completes. IDLE is reached exactly 800 cycles after that rise.
6. Assert `rst_n`=0 during STEP_HIGH → `drv_step` goes to 0 immediately, `position` reads 0, and no step occurs until re-enabled.

Source files
------------

// File: rtl/step_pkg.sv
// Shared definitions for the stepper step-pulse generator: FSM state encoding
// and default timing constants (in 50 MHz clk cycles).
package step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIR_SETUP = 2'd1,
        ST_STEP_HIGH = 2'd2,
        ST_STEP_LOW  = 2'd3
    } step_state_e;

    localparam int WIDTH_N_DEF    = 17;
    localparam int WIDTH_POS_DEF  = 32;
    localparam int PULSE_W_DEF    = 50;
    localparam int DIR_SETUP_DEF  = 25;
    localparam int MIN_PERIOD_DEF = 800;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter shared by the timed FSM states. A load of N-1 makes
// the owning state last exactly N cycles before o_zero is seen.
module step_timer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step-pulse generator: fixed-width drv_step pulses at a programmable period,
// direction setup before the first step after a reversal, signed position count.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int WIDTH_N    = WIDTH_N_DEF,
    parameter int PULSE_W    = PULSE_W_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int WIDTH_POS  = WIDTH_POS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_N-1:0]          period_in,
    input  logic                        period_valid,
    input  logic                        drv_enable_SM,
    input  logic                        drv_dir_in,
    output logic                        drv_step,
    output logic                        drv_dir,
    output logic                        busy,
    output logic                        step_done,
    output logic                        period_clamped,
    output logic signed [WIDTH_POS-1:0] position
);

    localparam logic [WIDTH_N-1:0] L_MIN_PERIOD = WIDTH_N'(MIN_PERIOD);
    localparam logic [WIDTH_N-1:0] L_HIGH_LOAD  = WIDTH_N'(PULSE_W - 1);
    localparam logic [WIDTH_N-1:0] L_SETUP_LOAD = WIDTH_N'(DIR_SETUP - 1);
    localparam logic [WIDTH_N-1:0] L_LOW_ADJ    = WIDTH_N'(PULSE_W + 1);

    step_state_e          r_state;
    logic [WIDTH_N-1:0]   r_shadow;
    logic [WIDTH_N-1:0]   r_active;
    logic                 r_enable;
    logic                 r_dir_in;
    logic                 r_drv_step;
    logic                 r_drv_dir;
    logic                 r_busy;
    logic                 r_step_done;
    logic                 r_clamped;
    logic [WIDTH_POS-1:0] r_position;

    step_state_e          w_next_state;
    logic                 w_timer_load;
    logic [WIDTH_N-1:0]   w_timer_val;
    logic                 w_timer_zero;

    step_timer #(
        .WIDTH (WIDTH_N)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_timer_zero)
    );

    // Enable and direction are registered once; motion decisions only look at
    // these copies, which gives the one-cycle start latency from IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && (r_shadow != '0)) begin
                    w_next_state = (r_dir_in != r_drv_dir) ? ST_DIR_SETUP : ST_STEP_HIGH;
                end
            end
            ST_DIR_SETUP: begin
                if (w_timer_zero) w_next_state = ST_STEP_HIGH;
            end
            ST_STEP_HIGH: begin
                if (w_timer_zero) w_next_state = ST_STEP_LOW;
            end
            ST_STEP_LOW: begin
                if (w_timer_zero) begin
                    if (!r_enable || (r_shadow == '0)) begin
                        w_next_state = ST_IDLE;
                    end else if (r_dir_in != r_drv_dir) begin
                        w_next_state = ST_DIR_SETUP;
                    end else begin
                        w_next_state = ST_STEP_HIGH;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Every transition enters a different state, so a state change is the
    // timer reload point; the low phase uses the period latched on the rise.
    always_comb begin
        w_timer_load = (w_next_state != r_state);
        w_timer_val  = '0;
        case (w_next_state)
            ST_DIR_SETUP: w_timer_val = L_SETUP_LOAD;
            ST_STEP_HIGH: w_timer_val = L_HIGH_LOAD;
            ST_STEP_LOW:  w_timer_val = r_active - L_LOW_ADJ;
            default:      w_timer_val = '0;
        endcase
    end

    // period_valid is a single-cycle strobe with no back-pressure: the word is
    // captured on the edge it is seen, and a boundary on that same edge still
    // uses the previous shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_active    <= '0;
            r_enable    <= 1'b0;
            r_dir_in    <= 1'b0;
            r_drv_step  <= 1'b0;
            r_drv_dir   <= 1'b0;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
            r_clamped   <= 1'b0;
            r_position  <= '0;
        end else begin
            r_enable    <= drv_enable_SM;
            r_dir_in    <= drv_dir_in;
            r_step_done <= 1'b0;
            r_clamped   <= 1'b0;

            if (period_valid) begin
                if (period_in == '0) begin
                    r_shadow <= '0;
                end else if (period_in < L_MIN_PERIOD) begin
                    r_shadow  <= L_MIN_PERIOD;
                    r_clamped <= 1'b1;
                end else begin
                    r_shadow <= period_in;
                end
            end

            r_state <= w_next_state;
            r_busy  <= (w_next_state != ST_IDLE);

            if (w_next_state != r_state) begin
                case (w_next_state)
                    ST_DIR_SETUP: begin
                        r_drv_dir  <= r_dir_in;
                        r_drv_step <= 1'b0;
                    end
                    ST_STEP_HIGH: begin
                        r_active    <= r_shadow;
                        r_drv_step  <= 1'b1;
                        r_step_done <= 1'b1;
                        if (r_drv_dir) begin
                            r_position <= r_position + WIDTH_POS'(1);
                        end else begin
                            r_position <= r_position - WIDTH_POS'(1);
                        end
                    end
                    default: begin
                        r_drv_step <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign drv_step       = r_drv_step;
    assign drv_dir        = r_drv_dir;
    assign busy           = r_busy;
    assign step_done      = r_step_done;
    assign period_clamped = r_clamped;
    assign position       = $signed(r_position);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: stimulus pushes the expected step
// {interval, dir, position} into a queue, a monitor pops one per step_done.
module tb_step_pulse_gen;

    localparam int W = 53;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] period_in;
    logic        period_valid;
    logic        drv_enable_SM;
    logic        drv_dir_in;
    logic        drv_step;
    logic        drv_dir;
    logic        busy;
    logic        step_done;
    logic        period_clamped;
    logic signed [31:0] position;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned last_rise = 0;
    int          hi_cnt = 0;
    logic [W-1:0] exp_q[$];

    step_pulse_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .period_in      (period_in),
        .period_valid   (period_valid),
        .drv_enable_SM  (drv_enable_SM),
        .drv_dir_in     (drv_dir_in),
        .drv_step       (drv_step),
        .drv_dir        (drv_dir),
        .busy           (busy),
        .step_done      (step_done),
        .period_clamped (period_clamped),
        .position       (position)
    );

    // clock / cycle counter
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned iv, input logic dir, input logic [31:0] pos);
        logic [19:0] iv20;
        iv20 = iv[19:0];
        exp_q.push_back({iv20, dir, pos});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_period(input int unsigned p, input logic exp_clamp);
        @(negedge clk);
        period_in    = p[16:0];
        period_valid = 1'b1;
        @(negedge clk);
        period_valid = 1'b0;
        check("period_clamped", {63'b0, period_clamped}, {63'b0, exp_clamp});
        @(negedge clk);
        check("clamp_one_cycle", {63'b0, period_clamped}, 64'd0);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected steps missing after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(input int budget, input string name, input int unsigned exp_dt);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(cyc - last_rise), 64'(exp_dt));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n !== 1'b1) begin
            hi_cnt = 0;
        end else begin
            if (drv_step === 1'b1) begin
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                check("pulse_width", 64'(hi_cnt), 64'd50);
                hi_cnt = 0;
            end
            if (step_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step: got step at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e[52:33] != 20'd0) check("step_interval", 64'(cyc - last_rise), {44'b0, e[52:33]});
                    check("step_dir", {63'b0, drv_dir}, {63'b0, e[32]});
                    check("step_position", {32'b0, position}, {32'b0, e[31:0]});
                    check("step_level", {63'b0, drv_step}, 64'd1);
                end
                last_rise = cyc;
            end
        end
    end

    initial begin
        int unsigned c_dir;
        int n;
        rst_n         = 1'b0;
        period_in     = '0;
        period_valid  = 1'b0;
        drv_enable_SM = 1'b0;
        drv_dir_in    = 1'b0;
        wait_cycles(3);
        check("rst_drv_step", {63'b0, drv_step}, 64'd0);
        check("rst_drv_dir", {63'b0, drv_dir}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_step_done", {63'b0, step_done}, 64'd0);
        check("rst_clamped", {63'b0, period_clamped}, 64'd0);
        check("rst_position", {32'b0, position}, 64'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: period 800, direction 0, counting down
        push_exp(0, 1'b0, -32'sd1);
        push_exp(800, 1'b0, -32'sd2);
        push_exp(800, 1'b0, -32'sd3);
        load_period(800, 1'b0);
        check("idle_no_step", {63'b0, busy}, 64'd0);
        drv_enable_SM = 1'b1;
        @(negedge clk);
        check("start_edge_k", {63'b0, drv_step}, 64'd0);
        @(negedge clk);
        check("start_edge_k1", {63'b0, drv_step}, 64'd1);
        check("start_busy", {63'b0, busy}, 64'd1);
        wait_drain(3000, "t1_steps");

        // 2: 39600 loaded mid-period applies only from the next boundary
        wait_cycles(100);
        push_exp(800, 1'b0, -32'sd4);
        load_period(39600, 1'b0);
        wait_drain(1000, "t2_boundary");
        push_exp(39600, 1'b0, -32'sd5);
        push_exp(800, 1'b0, -32'sd6);
        load_period(800, 1'b0);
        wait_drain(41000, "t2_long");

        // 3: reversal during STEP_LOW
        wait_cycles(100);
        drv_dir_in = 1'b1;
        push_exp(825, 1'b1, -32'sd5);
        push_exp(800, 1'b1, -32'sd4);
        wait_cycles(10);
        check("dir_held_mid_step", {63'b0, drv_dir}, 64'd0);
        wait_drain(3000, "t3_reverse");

        // 4: clamping, then stop via period 0
        push_exp(800, 1'b1, -32'sd3);
        load_period(100, 1'b1);
        wait_drain(1000, "t4_clamp100");
        push_exp(800, 1'b1, -32'sd2);
        load_period(799, 1'b1);
        wait_drain(1000, "t4_clamp799");
        push_exp(800, 1'b1, -32'sd1);
        wait_drain(1000, "t4_run");
        load_period(0, 1'b0);
        wait_idle(1000, "stop_latency", 800);
        check("stop_busy", {63'b0, busy}, 64'd0);
        check("stop_drv_step", {63'b0, drv_step}, 64'd0);

        // 5: enable dropped 10 cycles into the pulse
        push_exp(0, 1'b1, 32'sd0);
        load_period(800, 1'b0);
        wait_drain(100, "t5_restart");
        wait_cycles(9);
        drv_enable_SM = 1'b0;
        wait_cycles(5);
        check("enable_drop_high", {63'b0, drv_step}, 64'd1);
        wait_idle(1000, "enable_drop_idle", 800);
        check("enable_drop_step", {63'b0, drv_step}, 64'd0);
        check("enable_drop_pos", {32'b0, position}, 64'd0);

        // 6: reset during STEP_HIGH
        wait_cycles(5);
        push_exp(0, 1'b1, 32'sd1);
        drv_enable_SM = 1'b1;
        wait_drain(100, "t6_start");
        wait_cycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_step", {63'b0, drv_step}, 64'd0);
        check("async_rst_pos", {32'b0, position}, 64'd0);
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        drv_enable_SM = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(200);
        check("post_rst_idle", {63'b0, busy}, 64'd0);
        check("post_rst_dir", {63'b0, drv_dir}, 64'd0);

        // re-enable after reset: drv_dir is 0, request 1 -> setup then step
        push_exp(0, 1'b1, 32'sd1);
        drv_enable_SM = 1'b1;
        load_period(800, 1'b0);
        n = 0;
        while (drv_dir !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        c_dir = cyc;
        check("dir_change_seen", {63'b0, drv_dir}, 64'd1);
        wait_drain(200, "t6_setup_step");
        check("dir_setup_gap", 64'(last_rise - c_dir), 64'd25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1900000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
